// File: rtl/bitbrick_pkg.sv
// Shared types and constants for the bitbrick temporal multiply sequencer.
package bitbrick_pkg;

  localparam int BRICK_W      = 2;
  localparam int BB_PROD_W    = 10;
  localparam int BB_MAX_SHIFT = 4;
  localparam int ACC_W        = 16;
  localparam int OPERAND_W    = 8;

  typedef enum logic [1:0] {
    P2     = 2'd0,
    P4     = 2'd1,
    P8     = 2'd2,
    P_RSVD = 2'd3
  } prec_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of the most significant brick; the reserved code behaves as 8b.
  function automatic logic [1:0] last_slice(input prec_e p);
    case (p)
      P2:      last_slice = 2'd0;
      P4:      last_slice = 2'd1;
      default: last_slice = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/bitbrick_slice_sel.sv
// Picks one 2-bit brick out of an operand and flags it signed when it is
// the top brick of a two's-complement operand.
module bitbrick_slice_sel
  import bitbrick_pkg::*;
(
  input  logic [OPERAND_W-1:0] operand,
  input  logic [1:0]           index,
  input  prec_e                prec,
  input  logic                 is_signed,
  output logic [BRICK_W-1:0]   slice,
  output logic                 slice_signed
);

  always_comb begin
    slice        = operand[{index, 1'b0} +: BRICK_W];
    slice_signed = is_signed && (index == last_slice(prec));
  end

endmodule

// File: rtl/bitbrick_sequencer.sv
// Multi-cycle 2/4/8-bit multiply driving one external 2x2 bitbrick and
// accumulating its shifted partial products into a 16-bit result.
module bitbrick_sequencer
  import bitbrick_pkg::*;
#(
  parameter int P_ACC_W = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [1:0]           a_prec,
  input  logic [1:0]           b_prec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_ACC_W-1:0]   result,
  output logic [BRICK_W-1:0]   bb_x,
  output logic [BRICK_W-1:0]   bb_y,
  output logic                 bb_sx,
  output logic                 bb_sy,
  output logic [2:0]           bb_shift,
  input  logic [BB_PROD_W-1:0] bb_prod
);

  state_e                 state;
  logic [OPERAND_W-1:0]   a_q;
  logic [OPERAND_W-1:0]   b_q;
  logic                   a_signed_q;
  logic                   b_signed_q;
  prec_e                  a_prec_q;
  prec_e                  b_prec_q;
  logic [1:0]             idx_i;
  logic [1:0]             idx_j;
  logic [P_ACC_W-1:0]     acc;

  logic [BRICK_W-1:0]     slice_a;
  logic [BRICK_W-1:0]     slice_b;
  logic                   slice_a_signed;
  logic                   slice_b_signed;
  logic [3:0]             total_shift;
  logic [2:0]             brick_shift;
  logic [3:0]             residual_shift;
  logic [P_ACC_W-1:0]     prod_ext;
  logic [P_ACC_W-1:0]     addend;
  logic                   running;

  bitbrick_slice_sel u_sel_a (
    .operand      (a_q),
    .index        (idx_i),
    .prec         (a_prec_q),
    .is_signed    (a_signed_q),
    .slice        (slice_a),
    .slice_signed (slice_a_signed)
  );

  bitbrick_slice_sel u_sel_b (
    .operand      (b_q),
    .index        (idx_j),
    .prec         (b_prec_q),
    .is_signed    (b_signed_q),
    .slice        (slice_b),
    .slice_signed (slice_b_signed)
  );

  // The bitbrick absorbs up to BB_MAX_SHIFT; the rest is applied before the add.
  always_comb begin
    running        = (state == RUN);
    total_shift    = {1'b0, idx_i, 1'b0} + {1'b0, idx_j, 1'b0};
    brick_shift    = (total_shift > 4'(BB_MAX_SHIFT)) ? 3'(BB_MAX_SHIFT) : total_shift[2:0];
    residual_shift = total_shift - {1'b0, brick_shift};
    prod_ext       = {{(P_ACC_W-BB_PROD_W){bb_prod[BB_PROD_W-1]}}, bb_prod};
    addend         = prod_ext << residual_shift;

    bb_x     = running ? slice_a        : '0;
    bb_y     = running ? slice_b        : '0;
    bb_sx    = running ? slice_a_signed : 1'b0;
    bb_sy    = running ? slice_b_signed : 1'b0;
    bb_shift = running ? brick_shift    : 3'd0;
  end

  assign result = acc;

  // j walks the b bricks in the outer loop, i walks the a bricks inside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      acc        <= '0;
      idx_i      <= '0;
      idx_j      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      a_prec_q   <= P2;
      b_prec_q   <= P2;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            a_signed_q <= a_signed;
            b_signed_q <= b_signed;
            a_prec_q   <= prec_e'(a_prec);
            b_prec_q   <= prec_e'(b_prec);
            acc        <= '0;
            idx_i      <= '0;
            idx_j      <= '0;
            in_ready   <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (idx_i == last_slice(a_prec_q)) begin
            idx_i <= '0;
            if (idx_j == last_slice(b_prec_q)) begin
              idx_j     <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx_j <= idx_j + 2'd1;
            end
          end else begin
            idx_i <= idx_i + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitbrick_sequencer.sv
// Directed self-checking bench for bitbrick_sequencer with a behavioural
// 2x2 bitbrick closing the combinational product loop.
module tb_bitbrick_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        a_signed;
  logic        b_signed;
  logic [1:0]  a_prec;
  logic [1:0]  b_prec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [1:0]  bb_x;
  logic [1:0]  bb_y;
  logic        bb_sx;
  logic        bb_sy;
  logic [2:0]  bb_shift;
  logic [9:0]  bb_prod;

  int checks = 0;
  int errors = 0;
  int latency;
  logic [2:0] shifts [0:31];
  logic [1:0] last_x;
  logic       last_sx;

  always #5 clk = ~clk;

  bitbrick_sequencer #(.P_ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .a_prec    (a_prec),
    .b_prec    (b_prec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .bb_x      (bb_x),
    .bb_y      (bb_y),
    .bb_sx     (bb_sx),
    .bb_sy     (bb_sy),
    .bb_shift  (bb_shift),
    .bb_prod   (bb_prod)
  );

  // Behavioural bitbrick: signed/unsigned 2x2 multiply, shifted by bb_shift.
  always_comb begin
    logic signed [9:0] xe;
    logic signed [9:0] ye;
    logic signed [9:0] p;
    xe = bb_sx ? {{8{bb_x[1]}}, bb_x} : {8'b0, bb_x};
    ye = bb_sy ? {{8{bb_y[1]}}, bb_y} : {8'b0, bb_y};
    p  = xe * ye;
    bb_prod = p << bb_shift;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Launches one op, then walks RUN recording bb_shift until out_valid.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic as, input logic bs,
                               input logic [1:0] ap, input logic [1:0] bp);
    int cnt;
    @(negedge clk);
    a = av; b = bv; a_signed = as; b_signed = bs; a_prec = ap; b_prec = bp;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt <= 64) begin
      if (cnt <= 32) shifts[cnt-1] = bb_shift;
      last_x  = bb_x;
      last_sx = bb_sx;
      @(negedge clk);
      cnt++;
    end
    latency = cnt;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic as, input logic bs,
                       input logic [1:0] ap, input logic [1:0] bp,
                       input int n, input logic [15:0] expected);
    applyStimulus(av, bv, as, bs, ap, bp);
    checkOutput({tag, "_latency"}, 32'(latency), 32'(n + 1));
    checkOutput({tag, "_result"}, {16'b0, result}, {16'b0, expected});
    releaseResult();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; a_prec = '0; b_prec = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_result", {16'b0, result}, 32'd0);
    checkOutput("reset_bb", {24'b0, bb_x, bb_y, bb_sx, bb_sy, bb_shift}, 32'd0);

    // -2 x -1, 2b signed
    runOp("s2x2", 8'h02, 8'h03, 1'b1, 1'b1, 2'd0, 2'd0, 1, 16'h0002);
    checkOutput("idle_after_release", {31'b0, in_ready}, 32'd1);

    // 15 x 15, 4b unsigned, with the bitbrick shift sequence
    runOp("u4x4", 8'h0F, 8'h0F, 1'b0, 1'b0, 2'd1, 2'd1, 4, 16'd225);
    checkOutput("u4x4_shift0", {29'b0, shifts[0]}, 32'd0);
    checkOutput("u4x4_shift1", {29'b0, shifts[1]}, 32'd2);
    checkOutput("u4x4_shift2", {29'b0, shifts[2]}, 32'd2);
    checkOutput("u4x4_shift3", {29'b0, shifts[3]}, 32'd4);

    // -128 x 127, 8b signed; last brick pair is (3,3)
    runOp("s8x8", 8'h80, 8'h7F, 1'b1, 1'b1, 2'd2, 2'd2, 16, 16'hC080);
    checkOutput("s8x8_last_shift", {29'b0, shifts[15]}, 32'd4);
    checkOutput("s8x8_last_x", {30'b0, last_x}, 32'd2);
    checkOutput("s8x8_last_sx", {31'b0, last_sx}, 32'd1);

    // -1 (8b signed) x 15 (4b unsigned)
    runOp("mixed", 8'hFF, 8'h0F, 1'b1, 1'b0, 2'd2, 2'd1, 8, 16'hFFF1);
    // 255 x 255 unsigned fills the accumulator
    runOp("u8x8_max", 8'hFF, 8'hFF, 1'b0, 1'b0, 2'd2, 2'd2, 16, 16'hFE01);
    // reserved precision code behaves as 8b: 200 x 3
    runOp("rsvd_prec", 8'hC8, 8'h03, 1'b0, 1'b0, 2'd3, 2'd0, 4, 16'd600);
    // upper operand bits beyond the precision are ignored: 0xF6 as 2b signed = -2, times 1
    runOp("ignore_hi", 8'hF6, 8'h01, 1'b1, 1'b0, 2'd0, 2'd0, 1, 16'hFFFE);

    // Backpressure: hold the result five cycles, ignore an in_valid pulse
    applyStimulus(8'h0F, 8'h0F, 1'b0, 1'b0, 2'd1, 2'd1);
    checkOutput("bp_latency", 32'(latency), 32'd5);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_result", {16'b0, result}, 32'd225);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      a = 8'h03; b = 8'h03; a_prec = 2'd0; b_prec = 2'd0;
      in_valid = (k == 2);
      @(negedge clk);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_no_accept_on_handshake", {31'b0, in_ready}, 32'd1);

    // Reset during the third RUN cycle of an 8b op
    @(negedge clk);
    a = 8'h80; b = 8'h7F; a_signed = 1'b1; b_signed = 1'b1; a_prec = 2'd2; b_prec = 2'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_run_busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", {16'b0, result}, 32'd0);
    checkOutput("rst_bb", {24'b0, bb_x, bb_y, bb_sx, bb_sy, bb_shift}, 32'd0);
    runOp("after_rst", 8'h03, 8'h02, 1'b0, 1'b0, 2'd0, 2'd0, 1, 16'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
